// File: rtl/lzw_job_arbiter.sv
// lzw_job_arbiter: round-robin front end that shares a single LZW engine
// between NUM_REQ byte sources, forwarding bytes in and tagged codes out.
module lzw_job_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned MAX_LEN = 14,
    parameter int unsigned CODE_W  = 12,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*4-1:0] len_i,
    input  logic [NUM_REQ-1:0]   in_valid_i,
    input  logic [NUM_REQ*8-1:0] in_data_i,
    output logic [NUM_REQ-1:0]   in_ready_o,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic                 out_valid_o,
    output logic [CODE_W-1:0]    out_code_o,
    output logic                 out_last_o,
    output logic [2:0]           out_id_o,
    output logic                 busy_o,
    output logic                 err_len_o,
    output logic                 err_timeout_o,
    output logic                 eng_start_o,
    output logic [3:0]           eng_len_o,
    output logic                 eng_byte_valid_o,
    output logic [7:0]           eng_byte_o,
    input  logic                 eng_byte_ready_i,
    input  logic                 eng_code_valid_i,
    input  logic [CODE_W-1:0]    eng_code_i,
    input  logic                 eng_done_i
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, GRANT, FEED, DRAIN, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      winner_q;
    logic [2:0]      ptr_q;
    logic [3:0]      len_q;
    logic [3:0]      byte_cnt_q;
    logic [TW-1:0]   idle_cnt_q;

    logic [2:0]      pick;
    logic [3:0]      pick_len;
    logic            found;
    logic [3:0]      idx;
    logic            lane_valid;
    logic [7:0]      lane_data;
    logic            len_bad;
    logic            active;
    logic            hs;
    logic            code_fwd;
    logic            timeout_hit;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        pick     = '0;
        pick_len = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 4'(ptr_q) + 4'(k);
            if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && idx == 4'(j) && req_i[j]) begin
                    found = 1'b1;
                    pick  = 3'(j);
                end
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (pick == 3'(j)) pick_len = len_i[j*4 +: 4];
        end
    end

    // Select the granted requester's byte lane and derive progress events.
    always_comb begin
        lane_valid = 1'b0;
        lane_data  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (winner_q == 3'(j)) begin
                lane_valid = in_valid_i[j];
                lane_data  = in_data_i[j*8 +: 8];
            end
        end
        len_bad     = (len_q == 4'd0) || (32'(len_q) > MAX_LEN);
        active      = (state_q == FEED) || (state_q == DRAIN);
        hs          = (state_q == FEED) && lane_valid && eng_byte_ready_i;
        code_fwd    = active && eng_code_valid_i;
        // Abort on the edge where the idle count would reach TIMEOUT-1.
        timeout_hit = active && !hs && !eng_code_valid_i && !eng_done_i &&
                      (idle_cnt_q == TW'(TIMEOUT - 2));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d          = state_q;
        gnt_o            = '0;
        in_ready_o       = '0;
        busy_o           = (state_q != IDLE);
        err_len_o        = 1'b0;
        eng_start_o      = 1'b0;
        eng_len_o        = '0;
        eng_byte_valid_o = 1'b0;
        eng_byte_o       = '0;
        if (state_q != IDLE) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (winner_q == 3'(j)) gnt_o[j] = 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (found) state_d = GRANT;
            end
            GRANT: begin
                if (len_bad) begin
                    err_len_o = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    eng_start_o = 1'b1;
                    eng_len_o   = len_q;
                    state_d     = FEED;
                end
            end
            FEED: begin
                eng_byte_valid_o = lane_valid;
                eng_byte_o       = lane_data;
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (winner_q == 3'(j)) in_ready_o[j] = eng_byte_ready_i;
                end
                if (timeout_hit)                              state_d = RELEASE;
                else if (hs && byte_cnt_q == len_q - 4'd1)    state_d = DRAIN;
            end
            DRAIN: begin
                if (eng_done_i || timeout_hit) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job context, counters, registered code path and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            winner_q      <= '0;
            ptr_q         <= '0;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            out_valid_o   <= 1'b0;
            out_code_o    <= '0;
            out_last_o    <= 1'b0;
            out_id_o      <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            if (state_q == IDLE && found) begin
                winner_q <= pick;
                len_q    <= pick_len;
            end
            if (state_q == GRANT) begin
                byte_cnt_q <= '0;
                idle_cnt_q <= '0;
            end else if (active) begin
                if (hs) byte_cnt_q <= byte_cnt_q + 4'd1;
                if (hs || eng_code_valid_i) idle_cnt_q <= '0;
                else                        idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            out_valid_o <= code_fwd;
            out_code_o  <= code_fwd ? eng_code_i : '0;
            out_id_o    <= code_fwd ? winner_q : '0;
            out_last_o  <= (state_q == DRAIN) && eng_done_i;
            if (timeout_hit) err_timeout_o <= 1'b1;
            if (state_q == RELEASE) begin
                ptr_q <= (winner_q == 3'(NUM_REQ - 1)) ? 3'd0 : winner_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_lzw_job_arbiter.sv
// tb_lzw_job_arbiter: directed bench with a byte-to-code engine model and a
// scoreboard of expected tagged codes built from the requesters' source data.
module tb_lzw_job_arbiter;

    localparam int TOUT = 40;

    logic        clk;
    logic        reset_n_i;
    logic [1:0]  req_i;
    logic [7:0]  len_i;
    logic [1:0]  in_valid_i;
    logic [15:0] in_data_i;
    logic [1:0]  in_ready_o;
    logic [1:0]  gnt_o;
    logic        out_valid_o;
    logic [11:0] out_code_o;
    logic        out_last_o;
    logic [2:0]  out_id_o;
    logic        busy_o;
    logic        err_len_o;
    logic        err_timeout_o;
    logic        eng_start_o;
    logic [3:0]  eng_len_o;
    logic        eng_byte_valid_o;
    logic [7:0]  eng_byte_o;
    logic        eng_byte_ready_i;
    logic        eng_code_valid_i;
    logic [11:0] eng_code_i;
    logic        eng_done_i;

    lzw_job_arbiter #(.NUM_REQ(2), .MAX_LEN(14), .CODE_W(12), .TIMEOUT(TOUT)) dut (
        .clk(clk), .reset_n_i(reset_n_i), .req_i(req_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .gnt_o(gnt_o), .out_valid_o(out_valid_o), .out_code_o(out_code_o),
        .out_last_o(out_last_o), .out_id_o(out_id_o), .busy_o(busy_o),
        .err_len_o(err_len_o), .err_timeout_o(err_timeout_o),
        .eng_start_o(eng_start_o), .eng_len_o(eng_len_o),
        .eng_byte_valid_o(eng_byte_valid_o), .eng_byte_o(eng_byte_o),
        .eng_byte_ready_i(eng_byte_ready_i), .eng_code_valid_i(eng_code_valid_i),
        .eng_code_i(eng_code_i), .eng_done_i(eng_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  rx_q[$];
    int          gnt_log[$];
    int          gnt_dur[$];
    int n_start, n_errlen, n_last, last_cyc, idle_cyc, to_cyc, hs_cyc, gdur;
    logic [1:0]  prev_gnt = '0;
    logic        prev_busy = 1'b0;

    int          e_len, e_cnt;
    bit          e_hs, e_last;
    logic [7:0]  e_byte;
    bit          mute, rdy_mode, gap_mode;

    logic [7:0]  src_mem [2][16];
    int          src_len [2];
    int          src_idx [2];
    int          src_job [2];

    string s_ban = "banana_bandana";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {26'b0, gnt_o, in_ready_o, out_valid_o, out_code_o, out_last_o, out_id_o,
                busy_o, err_len_o, err_timeout_o, eng_start_o, eng_len_o,
                eng_byte_valid_o, eng_byte_o};
    endfunction

    task automatic load_src(input int r, input string s, input int total, input int job);
        for (int i = 0; i < s.len(); i++) src_mem[r][i] = s[i];
        src_len[r] = total;
        src_idx[r] = 0;
        src_job[r] = job;
    endtask

    task automatic clear_stats();
        exp_q.delete(); rx_q.delete(); gnt_log.delete(); gnt_dur.delete();
        n_start = 0; n_errlen = 0; n_last = 0; gdur = 0;
        last_cyc = -1; idle_cyc = -1; to_cyc = -1; hs_cyc = -1;
    endtask

    // One clock: observe at the falling edge, then drive just after the rising edge.
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (gnt_o != 2'b00) begin
            if (prev_gnt == 2'b00) begin
                gnt_log.push_back(gnt_o[1] ? 1 : 0);
                chk("gnt_onehot", 64'($onehot(gnt_o)), 64'd1);
            end
            gdur++;
        end else if (prev_gnt != 2'b00) begin
            gnt_dur.push_back(gdur);
            gdur = 0;
        end
        prev_gnt = gnt_o;
        if (eng_start_o) begin
            n_start++;
            e_len = int'(eng_len_o);
            e_cnt = 0;
        end
        if (err_len_o) n_errlen++;
        if (err_timeout_o && to_cyc < 0) to_cyc = cyc;
        e_hs = 1'b0;
        if (eng_byte_valid_o && eng_byte_ready_i) begin
            e_hs   = 1'b1;
            e_byte = eng_byte_o;
            e_cnt++;
            e_last = (e_cnt == e_len);
            rx_q.push_back(eng_byte_o);
            hs_cyc = cyc;
        end
        for (int r = 0; r < 2; r++) begin
            if (in_valid_i[r] && in_ready_o[r]) begin
                if (!mute) begin
                    e = {(src_idx[r] % src_job[r]) == (src_job[r] - 1), 3'(r), 4'hA,
                         src_mem[r][src_idx[r]]};
                    exp_q.push_back(e);
                end
                src_idx[r]++;
            end
        end
        if (out_valid_o) begin
            if (exp_q.size() == 0) chk("code_extra", 64'(exp_q.size()), 64'd1);
            else                   chk("code", {48'b0, out_last_o, out_id_o, out_code_o}, {48'b0, exp_q.pop_front()});
        end
        if (out_last_o) begin
            n_last++;
            last_cyc = cyc;
            chk("last_while_granted", 64'(gnt_o != 2'b00), 64'd1);
        end
        if (!busy_o && prev_busy) idle_cyc = cyc;
        prev_busy = busy_o;

        @(posedge clk);
        cyc++;
        #1;
        if (!reset_n_i) begin
            eng_code_valid_i = 1'b0;
            eng_code_i       = '0;
            eng_done_i       = 1'b0;
            e_cnt = 0; e_len = 0; e_hs = 1'b0;
            exp_q.delete();
        end else begin
            eng_code_valid_i = e_hs && !mute;
            eng_code_i       = {4'hA, e_byte};
            eng_done_i       = e_hs && e_last && !mute;
        end
        eng_byte_ready_i = rdy_mode ? (cyc % 2 == 0) : 1'b1;
        for (int r = 0; r < 2; r++) begin
            if (src_idx[r] < src_len[r] && !(gap_mode && (cyc % 3 == 2))) begin
                in_valid_i[r]        = 1'b1;
                in_data_i[r*8 +: 8]  = src_mem[r][src_idx[r]];
            end else begin
                in_valid_i[r]        = 1'b0;
                in_data_i[r*8 +: 8]  = 8'h00;
            end
        end
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(busy_o), 64'd0);
        tick();
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        req_i = '0;
        len_i = '0;
        src_len[0] = 0; src_len[1] = 0; src_idx[0] = 0; src_idx[1] = 0;
        tick();
        chk("rst_outputs", outs(), 64'd0);
        reset_n_i = 1'b1;
        clear_stats();
    endtask

    initial begin
        reset_n_i = 1'b0; req_i = '0; len_i = '0; in_valid_i = '0; in_data_i = '0;
        eng_byte_ready_i = 1'b1; eng_code_valid_i = 1'b0; eng_code_i = '0; eng_done_i = 1'b0;
        mute = 1'b0; rdy_mode = 1'b0; gap_mode = 1'b0; e_byte = '0; e_last = 1'b0;
        e_len = 0; e_cnt = 0;
        src_len[0] = 0; src_len[1] = 0; src_idx[0] = 0; src_idx[1] = 0;
        src_job[0] = 1; src_job[1] = 1;
        clear_stats();
        tick();

        // Single job, always-ready engine.
        do_reset();
        load_src(0, s_ban, 14, 14);
        len_i = {4'd0, 4'd14};
        req_i = 2'b01;
        tick();
        chk("t1_gnt", 64'(gnt_o), 64'd1);
        chk("t1_start", {eng_start_o, eng_len_o}, {1'b1, 4'd14});
        req_i = 2'b00;
        tick();
        chk("t1_feed", {eng_start_o, in_ready_o, busy_o}, {1'b0, 2'b01, 1'b1});
        wait_idle("t1_idle", 100);
        chk("t1_starts", n_start, 1);
        chk("t1_rx_count", rx_q.size(), 14);
        for (int i = 0; i < 14 && i < rx_q.size(); i++) chk("t1_rx_byte", rx_q[i], s_ban[i]);
        chk("t1_last_count", n_last, 1);
        chk("t1_idle_after_release", idle_cyc, last_cyc + 1);
        chk("t1_codes_left", exp_q.size(), 0);

        // Fairness with both requesters held.
        do_reset();
        load_src(0, "ABCDEFGH", 8, 4);
        load_src(1, "abcdefgh", 8, 4);
        len_i = {4'd4, 4'd4};
        req_i = 2'b11;
        for (int n = 0; n < 300 && gnt_log.size() < 4; n++) tick();
        req_i = 2'b00;
        chk("t2_grants", gnt_log.size(), 4);
        wait_idle("t2_idle", 100);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("t2_order", gnt_log[i], i % 2);
        chk("t2_starts", n_start, 4);
        chk("t2_lasts", n_last, 4);
        chk("t2_rx_count", rx_q.size(), 16);
        chk("t2_codes_left", exp_q.size(), 0);

        // Length errors: zero, then fifteen (and pointer advance).
        do_reset();
        len_i = {4'd0, 4'd0};
        req_i = 2'b01;
        tick();
        chk("t3_gnt0", {gnt_o, err_len_o, eng_start_o}, {2'b01, 1'b1, 1'b0});
        req_i = 2'b00;
        wait_idle("t3_idle0", 20);
        len_i = {4'd15, 4'd15};
        req_i = 2'b11;
        tick();
        chk("t3_gnt1", {gnt_o, err_len_o, eng_start_o}, {2'b10, 1'b1, 1'b0});
        req_i = 2'b00;
        wait_idle("t3_idle1", 20);
        chk("t3_errlen", n_errlen, 2);
        chk("t3_starts", n_start, 0);
        chk("t3_durs", gnt_dur.size(), 2);
        for (int i = 0; i < gnt_dur.size(); i++) chk("t3_dur", gnt_dur[i], 2);

        // Backpressure: toggling ready and gapped valid, one surplus byte offered.
        do_reset();
        rdy_mode = 1'b1;
        gap_mode = 1'b1;
        load_src(0, {s_ban, "X"}, 15, 14);
        len_i = {4'd0, 4'd14};
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        wait_idle("t4_idle", 200);
        chk("t4_rx_count", rx_q.size(), 14);
        for (int i = 0; i < 14 && i < rx_q.size(); i++) chk("t4_rx_byte", rx_q[i], s_ban[i]);
        chk("t4_src_consumed", src_idx[0], 14);
        chk("t4_last_count", n_last, 1);
        chk("t4_codes_left", exp_q.size(), 0);
        rdy_mode = 1'b0;
        gap_mode = 1'b0;

        // Timeout: engine takes bytes but never returns codes.
        do_reset();
        mute = 1'b1;
        load_src(0, "wxyz", 4, 4);
        len_i = {4'd0, 4'd4};
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        wait_idle("t5_idle", 200);
        chk("t5_timeout_cycle", to_cyc, hs_cyc + TOUT);
        chk("t5_no_last", n_last, 0);
        chk("t5_rx_count", rx_q.size(), 4);
        repeat (3) tick();
        chk("t5_sticky", 64'(err_timeout_o), 64'd1);
        mute = 1'b0;

        // Reset mid-job (pointer sits at 1 here).
        clear_stats();
        load_src(1, s_ban, 14, 14);
        len_i = {4'd14, 4'd0};
        req_i = 2'b10;
        tick();
        chk("t6_gnt", 64'(gnt_o), 64'd2);
        req_i = 2'b00;
        repeat (3) tick();
        chk("t6_in_feed", {in_ready_o, eng_byte_valid_o}, {2'b10, 1'b1});
        reset_n_i = 1'b0;
        tick();
        chk("t6_rst_outputs", outs(), 64'd0);
        reset_n_i = 1'b1;
        clear_stats();
        load_src(0, "pqrs", 4, 4);
        load_src(1, "tuvw", 4, 4);
        len_i = {4'd4, 4'd4};
        req_i = 2'b11;
        tick();
        chk("t6_regrant", 64'(gnt_o), 64'd1);
        req_i = 2'b00;
        wait_idle("t6_idle", 100);
        chk("t6_last_count", n_last, 1);
        chk("t6_codes_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
